// File: rtl/systolic_skew_feeder.sv
// Skews each accepted input vector so that element i reaches array row i
// i+1 cycles after acceptance, and tracks tile boundaries to pulse done.
module systolic_skew_feeder #(
   parameter int D_BW = 8,
   parameter int N    = 4
) (
   input  logic              en_clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [N*D_BW-1:0] s_data,
   input  logic              s_last,
   output logic [N*D_BW-1:0] out_d,
   output logic [N-1:0]      out_v,
   output logic              busy,
   output logic              done
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;
   localparam int         CW       = $clog2(N);

   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [N-1:0]  r_last_sh;
   logic          w_accept;

   assign s_ready  = (r_state != S_DRAIN);
   assign w_accept = s_valid & s_ready;
   assign busy     = (r_state == S_STREAM) || (r_state == S_DRAIN);
   assign done     = r_last_sh[N-1];

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge en_clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_STREAM: begin
               if (w_accept) begin
                  if (s_last) begin
                     r_state <= S_DRAIN;
                     r_cnt   <= CW'(N - 1);
                  end else begin
                     r_state <= S_STREAM;
                  end
               end
            end
            S_DRAIN: begin
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Tile-end marker travels alongside row N-1 so done lines up with its last element.
   always_ff @(posedge en_clk) begin
      if (rst) r_last_sh <= '0;
      else     r_last_sh <= {r_last_sh[N-2:0], w_accept & s_last};
   end

   for (genvar g_row = 0; g_row < N; g_row++) begin : g_line
      logic [D_BW-1:0] r_d [g_row+1];
      logic [g_row:0]  r_v;

      // NOTE: the skew lines are reset so an aborted tile leaves nothing in flight.
      always_ff @(posedge en_clk) begin
         if (rst) begin
            r_d <= '{default: '0};
            r_v <= '0;
         end else begin
            r_d[0] <= w_accept ? s_data[g_row*D_BW +: D_BW] : '0;
            r_v[0] <= w_accept;
            for (int j = 1; j <= g_row; j++) begin
               r_d[j] <= r_d[j-1];
               r_v[j] <= r_v[j-1];
            end
         end
      end

      assign out_d[g_row*D_BW +: D_BW] = r_d[g_row];
      assign out_v[g_row]              = r_v[g_row];
   end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: each accepted vector pushes per-row
// expectations with their arrival cycle; a negedge monitor pops and compares.
module tb_systolic_skew_feeder;

   localparam int D_BW = 8;
   localparam int N    = 4;
   localparam int W    = N * D_BW;

   typedef struct {
      int              row;
      int              t;
      logic [D_BW-1:0] d;
   } exp_t;

   logic         en_clk = 1'b0;
   logic         rst;
   logic         s_valid;
   logic         s_ready;
   logic [W-1:0] s_data;
   logic         s_last;
   logic [W-1:0] out_d;
   logic [N-1:0] out_v;
   logic         busy;
   logic         done;

   int   cyc    = 0;
   int   errors = 0;
   int   checks = 0;
   bit   mon_en = 1'b0;
   exp_t q_exp[$];
   int   q_done[$];

   systolic_skew_feeder #(.D_BW(D_BW), .N(N)) dut (
      .en_clk (en_clk),
      .rst    (rst),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .s_data (s_data),
      .s_last (s_last),
      .out_d  (out_d),
      .out_v  (out_v),
      .busy   (busy),
      .done   (done)
   );

   always #5 en_clk = ~en_clk;
   always @(posedge en_clk) cyc <= cyc + 1;

   // Monitor: compare every row and done against the scoreboard each cycle.
   initial begin
      forever begin
         @(negedge en_clk);
         if (mon_en) begin
            for (int k = q_exp.size() - 1; k >= 0; k--) begin
               if (q_exp[k].t < cyc) begin
                  checks++; errors++;
                  $display("FAIL row%0d_missing: cycle %0d got nothing, required data %h at cycle %0d",
                           q_exp[k].row, cyc, q_exp[k].d, q_exp[k].t);
                  q_exp.delete(k);
               end
            end
            for (int i = 0; i < N; i++) begin
               logic [D_BW-1:0] obs;
               obs = out_d[i*D_BW +: D_BW];
               checks++;
               if (out_v[i] === 1'b1) begin
                  int idx;
                  idx = -1;
                  for (int k = 0; k < q_exp.size(); k++) begin
                     if (q_exp[k].row == i) begin
                        idx = k;
                        break;
                     end
                  end
                  if (idx < 0) begin
                     errors++;
                     $display("FAIL row%0d_unexpected: cycle %0d got valid data %h, required no valid", i, cyc, obs);
                  end else begin
                     if (q_exp[idx].t != cyc || obs !== q_exp[idx].d) begin
                        errors++;
                        $display("FAIL row%0d_data: cycle %0d got %h, required %h at cycle %0d",
                                 i, cyc, obs, q_exp[idx].d, q_exp[idx].t);
                     end
                     q_exp.delete(idx);
                  end
               end else if (out_v[i] !== 1'b0 || obs !== '0) begin
                  errors++;
                  $display("FAIL row%0d_bubble: cycle %0d got v=%b d=%h, required v=0 d=00", i, cyc, out_v[i], obs);
               end
            end
            if (q_done.size() > 0 && q_done[0] < cyc) begin
               checks++; errors++;
               $display("FAIL done_missing: cycle %0d no pulse, required at cycle %0d", cyc, q_done[0]);
               void'(q_done.pop_front());
            end
            if (done !== 1'b0) begin
               checks++;
               if (done === 1'b1 && q_done.size() > 0 && q_done[0] == cyc) begin
                  void'(q_done.pop_front());
               end else begin
                  errors++;
                  $display("FAIL done_spurious: cycle %0d got done=%b, required 0", cyc, done);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic v, input logic [W-1:0] d, input logic l, output logic acc);
      exp_t e;
      @(posedge en_clk); #1;
      s_valid = v;
      s_data  = d;
      s_last  = l;
      acc     = v && (s_ready === 1'b1);
      if (acc) begin
         for (int i = 0; i < N; i++) begin
            e.row = i;
            e.t   = cyc + i + 1;
            e.d   = d[i*D_BW +: D_BW];
            q_exp.push_back(e);
         end
         if (l) q_done.push_back(cyc + N);
      end
   endtask

   task automatic idle_cycles(input int n);
      logic acc;
      for (int k = 0; k < n; k++) drive(1'b0, W'($urandom), 1'b1, acc);
   endtask

   task automatic wait_idle();
      logic acc;
      int   k;
      k = 0;
      do begin
         drive(1'b0, W'($urandom), 1'b0, acc);
         k++;
      end while (busy !== 1'b0 && k < 20);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, k);
      end
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      s_valid = 1'b1;
      s_data  = W'(32'hAABBCCDD);
      s_last  = 1'b0;
      repeat (2) @(posedge en_clk);
      @(negedge en_clk);
      checks++;
      if (out_v !== '0 || out_d !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_during: v=%b d=%h busy=%b done=%b, required all 0", out_v, out_d, busy, done);
      end
      @(posedge en_clk); #1;
      rst     = 1'b0;
      s_valid = 1'b0;
      checks++;
      if (out_v !== '0 || out_d !== '0 || busy !== 1'b0 || done !== 1'b0 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_after: v=%b d=%h busy=%b done=%b ready=%b, required 0/0/0/0/1",
                  out_v, out_d, busy, done, s_ready);
      end
      mon_en = 1'b1;
   endtask

   task automatic test_basic();
      logic acc;
      drive(1'b1, W'(32'h04030201), 1'b0, acc);
      checks++;
      if (acc !== 1'b1) begin
         errors++;
         $display("FAIL basic_accept0: accepted=%b, required 1", acc);
      end
      drive(1'b1, W'(32'h14131211), 1'b1, acc);
      checks++;
      if (acc !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_accept1: accepted=%b busy=%b, required 1/1", acc, busy);
      end
      wait_idle();
   endtask

   task automatic test_bubble();
      logic acc;
      drive(1'b1, W'($urandom), 1'b0, acc);
      drive(1'b0, W'(32'hFFFFFFFF), 1'b1, acc);
      checks++;
      if (acc !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL bubble_stream: accepted=%b busy=%b, required 0/1", acc, busy);
      end
      drive(1'b1, W'($urandom), 1'b1, acc);
      wait_idle();
   endtask

   task automatic test_single();
      logic acc;
      drive(1'b1, W'($urandom), 1'b1, acc);
      for (int k = 1; k <= N - 1; k++) begin
         drive(1'b1, W'($urandom), 1'b0, acc);
         checks++;
         if (acc !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_drain%0d: ready=%b busy=%b, required 0/1", k, s_ready, busy);
         end
      end
      drive(1'b1, W'($urandom), 1'b1, acc);
      checks++;
      if (acc !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_next: accepted=%b busy=%b, required 1/0", acc, busy);
      end
      wait_idle();
   endtask

   task automatic test_reset_drain();
      logic acc;
      int   c;
      drive(1'b1, W'($urandom), 1'b1, acc);
      drive(1'b0, W'($urandom), 1'b0, acc);
      @(posedge en_clk); #1;
      rst     = 1'b1;
      s_valid = 1'b0;
      c       = cyc;
      @(negedge en_clk); #1;
      for (int k = q_exp.size() - 1; k >= 0; k--) if (q_exp[k].t > c) q_exp.delete(k);
      for (int k = q_done.size() - 1; k >= 0; k--) if (q_done[k] > c) q_done.delete(k);
      @(posedge en_clk); #1;
      rst = 1'b0;
      checks++;
      if (out_v !== '0 || out_d !== '0 || busy !== 1'b0 || done !== 1'b0 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_drain: v=%b d=%h busy=%b done=%b ready=%b, required 0/0/0/0/1",
                  out_v, out_d, busy, done, s_ready);
      end
      idle_cycles(N + 2);
   endtask

   task automatic test_back_to_back();
      logic acc;
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, W'($urandom), (k == 7), acc);
         checks++;
         if (acc !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept%0d: ready=%b, required 1", k, s_ready);
         end
      end
      wait_idle();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bubble();
      test_single();
      test_reset_drain();
      test_back_to_back();
      idle_cycles(N + 3);
      checks++;
      if (q_exp.size() != 0 || q_done.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty: %0d row and %0d done entries left, required 0",
                  q_exp.size(), q_done.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
